// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module : core_pkg
// Shared types and constants for the svx32 memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/svx32_arb_rr.sv
`default_nettype none
// ============================================================================
// Module : svx32_arb_rr
// Two-way round-robin picker: bit 0 = fetch, bit 1 = data; one-hot grant.
// Rev    : 1.0 - initial release
// ============================================================================
module svx32_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  import core_pkg::*;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   gnt_o = (last_i == REQ_DM) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule : svx32_arb_rr
`default_nettype wire

// File: rtl/svx32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : svx32_mem_arbiter
// Fetch/data arbiter onto one memory port, single outstanding transaction.
// Rev    : 1.0 - initial release
// ============================================================================
module svx32_mem_arbiter #(
  parameter int XLEN        = core_pkg::XLEN,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            pil_clk,
  input  logic            pil_rst_n,
  // fetch port
  input  logic            pil_if_req,
  input  logic [XLEN-1:0] piv_if_addr,
  output logic            pol_if_gnt,
  output logic            pol_if_valid,
  output logic [XLEN-1:0] pov_if_rdata,
  output logic            pol_if_err,
  // data port
  input  logic            pil_dm_req,
  input  logic            pil_dm_wen,
  input  logic [XLEN-1:0] piv_dm_addr,
  input  logic [XLEN-1:0] piv_dm_wdata,
  input  logic [3:0]      piv_dm_byte_sel,
  output logic            pol_dm_gnt,
  output logic            pol_dm_valid,
  output logic [XLEN-1:0] pov_dm_rdata,
  output logic            pol_dm_err,
  // memory port
  output logic            pol_mem_req,
  output logic            pol_mem_wen,
  output logic [XLEN-1:0] pov_mem_addr,
  output logic [XLEN-1:0] pov_mem_wdata,
  output logic [3:0]      pov_mem_byte_sel,
  input  logic            pil_mem_ack,
  input  logic            pil_mem_valid,
  input  logic [XLEN-1:0] piv_mem_rdata
);
  import core_pkg::*;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);

  arb_state_e      state_q, state_d;
  req_id_e         owner_q, owner_d;
  req_id_e         last_q, last_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            wen_q, wen_d;
  logic [3:0]      bsel_q, bsel_d;
  logic [9:0]      tmo_q, tmo_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic            rsp_err_q, rsp_err_d;
  req_id_e         rsp_own_q, rsp_own_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;

  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       busy;
  logic       done;

  svx32_arb_rr u_arb (
    .req_i  ({pil_dm_req, pil_if_req}),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Grants only leave the block from IDLE, and never while reset is held.
  assign gnt  = arb_gnt & {2{(state_q == ST_IDLE) && pil_rst_n}};
  assign busy = (state_q == ST_ADDR) || (state_q == ST_RESP);
  assign done = ((state_q == ST_ADDR) && pil_mem_ack && pil_mem_valid) ||
                ((state_q == ST_RESP) && pil_mem_valid);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wen_d      = wen_q;
    bsel_d     = bsel_q;
    tmo_d      = tmo_q;
    rsp_vld_d  = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_own_d  = rsp_own_q;
    rsp_data_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          owner_d = REQ_IF;
          last_d  = REQ_IF;
          addr_d  = piv_if_addr;
          wdata_d = '0;
          wen_d   = 1'b0;
          bsel_d  = 4'b1111;
          tmo_d   = '0;
          state_d = ST_ADDR;
        end else if (gnt[1]) begin
          owner_d = REQ_DM;
          last_d  = REQ_DM;
          addr_d  = piv_dm_addr;
          wdata_d = piv_dm_wdata;
          wen_d   = pil_dm_wen;
          bsel_d  = piv_dm_byte_sel;
          tmo_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (pil_mem_ack && !pil_mem_valid) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (busy) begin
      tmo_d = tmo_q + 10'd1;
    end

    // A completion in the same cycle as the last allowed one beats the timeout.
    if (done) begin
      state_d    = ST_IDLE;
      rsp_vld_d  = 1'b1;
      rsp_own_d  = owner_q;
      rsp_data_d = wen_q ? '0 : piv_mem_rdata;
    end else if (busy && (tmo_q == TMO_LAST)) begin
      state_d   = ST_IDLE;
      rsp_vld_d = 1'b1;
      rsp_err_d = 1'b1;
      rsp_own_d = owner_q;
    end
  end

  always_ff @(posedge pil_clk or negedge pil_rst_n) begin
    if (!pil_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= REQ_IF;
      last_q     <= REQ_DM;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      bsel_q     <= 4'b0000;
      tmo_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_own_q  <= REQ_IF;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      bsel_q     <= bsel_d;
      tmo_q      <= tmo_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_own_q  <= rsp_own_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign pol_if_gnt   = gnt[0];
  assign pol_dm_gnt   = gnt[1];
  assign pol_if_valid = rsp_vld_q && (rsp_own_q == REQ_IF);
  assign pol_dm_valid = rsp_vld_q && (rsp_own_q == REQ_DM);
  assign pol_if_err   = rsp_err_q && (rsp_own_q == REQ_IF);
  assign pol_dm_err   = rsp_err_q && (rsp_own_q == REQ_DM);
  assign pov_if_rdata = (rsp_own_q == REQ_IF) ? rsp_data_q : '0;
  assign pov_dm_rdata = (rsp_own_q == REQ_DM) ? rsp_data_q : '0;

  assign pol_mem_req      = (state_q == ST_ADDR);
  assign pol_mem_wen      = wen_q;
  assign pov_mem_addr     = addr_q;
  assign pov_mem_wdata    = wdata_q;
  assign pov_mem_byte_sel = bsel_q;

endmodule : svx32_mem_arbiter
`default_nettype wire
